// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Bit-serial receiver for a parity-protected frame. A frame is FRAME_LEN data
// bits, least significant bit first, followed by one parity bit. The block
// keeps a running XOR of the data bits and deserialises the word. It then
// compares the received parity bit against the expected one and presents the
// word plus a pass/fail flag on a valid/ready output. Frames that fail the
// check are counted in a saturating error counter.
//
// Parameters
//   FRAME_LEN   data bits per frame (2..32)
//   ODD_PARITY  0 = even parity, 1 = odd parity
//   ERR_W       width of the saturating parity-error counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   in_valid   in_bit is valid this cycle
//   in_ready   block accepts a bit this cycle (low while a result is held)
//   in_bit     serial data or parity bit
//   abort      discard the partially received frame (ignored while holding)
//   out_valid  out_data / out_ok are valid
//   out_ready  downstream accepts the output
//   out_data   deserialised word, bit 0 is the first bit received
//   out_ok     1 = received parity matched
//   err_cnt    number of frames with a parity error, saturates at all-ones
// -----------------------------------------------------------------------------
module serial_parity_checker #(
    parameter int FRAME_LEN  = 8,
    parameter int ODD_PARITY = 0,
    parameter int ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_data,
    output logic                 out_ok,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic            ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_PARITY  = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic                   r_acc;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [FRAME_LEN-1:0]   r_out_data;
    logic                   r_out_ok;
    logic                   r_out_valid;
    logic [ERR_W-1:0]       r_err_cnt;

    logic                   w_in_ready;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_last_bit;
    logic                   w_par_ok;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Received parity bit matches the parity implied by the data XOR.
    function automatic logic parity_match(input logic acc,
                                          input logic rx_bit,
                                          input logic odd);
        return rx_bit == (acc ^ odd);
    endfunction

    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_last_bit = (r_cnt == LAST_IDX);
    assign w_par_ok   = parity_match(r_acc, in_bit, ODD_BIT);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_COLLECT: begin
                // abort wins over a simultaneous bit transfer
                if (abort) begin
                    w_state_nxt = S_COLLECT;
                end else if (w_in_xfer && w_last_bit) begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (abort) begin
                    w_state_nxt = S_COLLECT;
                end else if (w_in_xfer) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // abort is deliberately not looked at: a finished frame is
                // always delivered
                if (w_out_xfer) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_in_ready = (r_state != S_HOLD);
    end

    // ---- datapath: collect, check, hold ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_ok    <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_COLLECT: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_acc   <= 1'b0;
                        r_shift <= '0;
                    end else if (w_in_xfer) begin
                        // Shifting in from the top leaves the first bit at
                        // bit 0 once all FRAME_LEN bits have arrived.
                        r_shift <= {in_bit, r_shift[FRAME_LEN-1:1]};
                        r_acc   <= r_acc ^ in_bit;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_acc   <= 1'b0;
                        r_shift <= '0;
                    end else if (w_in_xfer) begin
                        r_out_data  <= r_shift;
                        r_out_ok    <= w_par_ok;
                        r_out_valid <= 1'b1;
                        if (!w_par_ok) begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                        end
                    end
                end
                S_HOLD: begin
                    // out_data/out_ok are left untouched so they stay stable
                    // under backpressure and after the handshake.
                    if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_acc       <= 1'b0;
                        r_shift     <= '0;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_acc   <= 1'b0;
                    r_shift <= '0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ok    = r_out_ok;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         err;
    } exp_t;

    logic       clk;
    logic       rst;

    // default instance: even parity, 8-bit error counter
    logic       in_valid0, in_ready0, in_bit0, abort0;
    logic       out_valid0, out_ready0, out_ok0;
    logic [7:0] out_data0;
    logic [7:0] err_cnt0;

    // odd parity instance with a 2-bit error counter
    logic       in_valid1, in_ready1, in_bit1, abort1;
    logic       out_valid1, out_ready1, out_ok1;
    logic [7:0] out_data1;
    logic [1:0] err_cnt1;

    int checks;
    int errors;
    int exp_err0;
    int exp_err1;
    exp_t q0[$];
    exp_t q1[$];

    serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(0), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_bit(in_bit0), .abort(abort0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_ok(out_ok0), .err_cnt(err_cnt0)
    );

    serial_parity_checker #(.FRAME_LEN(8), .ODD_PARITY(1), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_bit(in_bit1), .abort(abort1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_ok(out_ok1), .err_cnt(err_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic b);
        if (sel == 0) begin
            in_valid0 = v;
            in_bit0   = b;
        end else begin
            in_valid1 = v;
            in_bit1   = b;
        end
    endtask

    // Hold the bit on the bus until an edge where in_ready is high.
    task automatic send_bit(input int sel, input logic b);
        bit done;
        done = 1'b0;
        set_in(sel, 1'b1, b);
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if ((sel == 0) ? in_ready0 : in_ready1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        set_in(sel, 1'b0, 1'b0);
        if (!done) check("send_bit_timeout", {31'd0, done}, 32'd1);
    endtask

    // Sends data LSB first then the parity bit; optionally records the
    // expected result computed from the data word itself.
    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par, input bit push);
        exp_t e;
        logic odd;
        logic exp_par;
        int   max_err;
        odd     = (sel == 1);
        max_err = (sel == 0) ? 255 : 3;
        for (int i = 0; i < 8; i++) send_bit(sel, data[i]);
        if (push) begin
            exp_par = (^data) ^ odd;
            e.data  = data;
            e.ok    = (par == exp_par);
            if (sel == 0) begin
                if (!e.ok && exp_err0 < max_err) exp_err0++;
                e.err = exp_err0;
                q0.push_back(e);
            end else begin
                if (!e.ok && exp_err1 < max_err) exp_err1++;
                e.err = exp_err1;
                q1.push_back(e);
            end
        end
        send_bit(sel, par);
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check((sel == 0) ? "drain0" : "drain1",
              (sel == 0) ? q0.size() : q1.size(), 32'd0);
    endtask

    // Scoreboard: an output handshake happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                check("d0_spurious_valid", {31'd0, out_valid0}, 32'd0);
            end else begin
                e = q0.pop_front();
                check("d0_out_data", {24'd0, out_data0}, {24'd0, e.data});
                check("d0_out_ok", {31'd0, out_ok0}, {31'd0, e.ok});
                check("d0_err_cnt", {24'd0, err_cnt0}, e.err);
            end
        end
        if (rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("d1_spurious_valid", {31'd0, out_valid1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("d1_out_data", {24'd0, out_data1}, {24'd0, e.data});
                check("d1_out_ok", {31'd0, out_ok1}, {31'd0, e.ok});
                check("d1_err_cnt", {30'd0, err_cnt1}, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the run finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        exp_err0 = 0;
        exp_err1 = 0;
        rst = 1'b0;
        in_valid0 = 0; in_bit0 = 0; abort0 = 0; out_ready0 = 1;
        in_valid1 = 0; in_bit1 = 0; abort1 = 0; out_ready1 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_out_ok", {31'd0, out_ok0}, 32'd0);
        check("rst_out_data", {24'd0, out_data0}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt0}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: 0xA5, even parity 0 -> ok, valid right after the parity edge
        for (int i = 0; i < 8; i++) send_bit(0, 8'hA5 >> i);
        check("t1_no_valid_before_parity", {31'd0, out_valid0}, 32'd0);
        q0.push_back('{data: 8'hA5, ok: 1'b1, err: 0});
        send_bit(0, 1'b0);
        check("t1_valid_latency", {31'd0, out_valid0}, 32'd1);
        check("t1_in_ready_low", {31'd0, in_ready0}, 32'd0);
        drain(0);

        // 2: 0x07 with wrong parity
        send_frame(0, 8'h07, 1'b0, 1'b1);
        drain(0);

        // 3: backpressure on 0x3C
        out_ready0 = 1'b0;
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {31'd0, out_valid0}, 32'd1);
            check("t3_hold_data", {24'd0, out_data0}, 32'h3C);
            check("t3_hold_ok", {31'd0, out_ok0}, 32'd1);
            check("t3_hold_in_ready", {31'd0, in_ready0}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        check("t3_in_ready_xfer_cycle", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1;
        check("t3_valid_dropped", {31'd0, out_valid0}, 32'd0);
        check("t3_in_ready_back", {31'd0, in_ready0}, 32'd1);
        check("t3_queue_empty", q0.size(), 32'd0);

        // 4: abort after 4 bits with a bit offered on the same edge
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        abort0 = 1'b1;
        in_valid0 = 1'b1;
        in_bit0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        in_valid0 = 1'b0;
        in_bit0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_output_after_abort", {31'd0, out_valid0}, 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        drain(0);

        // 5: odd parity, 2-bit counter saturates
        for (int f = 0; f < 4; f++) begin
            send_frame(1, 8'h00, 1'b0, 1'b1);
            drain(1);
        end
        check("t5_err_saturated", {30'd0, err_cnt1}, 32'd3);

        // 6a: reset after 5 bits
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err0 = 0;
        exp_err1 = 0;
        check("t6a_out_valid", {31'd0, out_valid0}, 32'd0);
        check("t6a_err_cnt", {24'd0, err_cnt0}, 32'd0);
        check("t6a_in_ready", {31'd0, in_ready0}, 32'd1);

        // 6b: reset while holding a result
        out_ready0 = 1'b0;
        send_frame(0, 8'h55, 1'b1, 1'b0);
        check("t6b_in_hold", {31'd0, out_valid0}, 32'd1);
        check("t6b_err_before_rst", {24'd0, err_cnt0}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("t6b_out_valid", {31'd0, out_valid0}, 32'd0);
        check("t6b_err_cnt", {24'd0, err_cnt0}, 32'd0);
        check("t6b_in_ready", {31'd0, in_ready0}, 32'd1);
        out_ready0 = 1'b1;
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        drain(0);
        repeat (3) @(posedge clk);
        #1;
        check("end_idle_valid", {31'd0, out_valid0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
